logic_core_arbiter: RTL and testbench

- Shares one instance of the 14-input / 8-output mapped combinational logic core among NUM_REQ requesters.
- Each requester sends one operand vector over a valid/ready handshake. The block arbitrates round-robin, drives the core and holds its inputs stable for CORE_LAT settle cycles.
- It captures the core result and returns it to the granted requester over a response handshake.
- It sits between the requester fabric and the unclocked core netlist. It is the only clocked element on the core's boundary.

---
 rtl/logic_core_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/logic_core_arbiter.sv | 119 +++++++++++
 tb/tb_logic_core_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_core_pkg.sv
// Shared types and helpers for the logic-core arbiter: FSM state encoding,
// core port widths and a one-hot decoder used for response steering.
package logic_core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int CORE_IN_W  = 14;
  localparam int CORE_OUT_W = 8;
  localparam int MAX_REQ    = 8;
  localparam int MAX_ID_W   = 3;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_ID_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after 'last'
// in cyclic order and reports it both one-hot and as an index.
module rr_arbiter #(
  parameter int N = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] cand [N];
  logic [N-1:0]    hit;
  logic            found;

  // cand[gi] is the requester examined at priority position gi
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = ID_W'((int'(last) + 1 + gi) % N);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && hit[i]) begin
        found          = 1'b1;
        gnt_id         = cand[i];
        gnt[cand[i]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_core_arbiter.sv
// Time-shares one unclocked combinational logic core among NUM_REQ requesters:
// round-robin accept, hold the operand CORE_LAT cycles, return the sampled result.
module logic_core_arbiter
  import logic_core_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int IN_W     = CORE_IN_W,
  parameter int OUT_W    = CORE_OUT_W,
  parameter int CORE_LAT = 2,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]         core_in,
  input  logic [OUT_W-1:0]        core_out,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [OUT_W-1:0]        rsp_data,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  state_t             state_reg, state_next;
  logic [3:0]         cnt_reg;
  logic [ID_W-1:0]    last_reg;
  logic [ID_W-1:0]    grant_id_reg;
  logic [ID_W-1:0]    arb_id;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [IN_W-1:0]    core_in_reg;
  logic [OUT_W-1:0]   rsp_data_reg;
  logic [IN_W-1:0]    req_op [NUM_REQ];
  logic               accept;
  logic               capture;
  logic               done;
  logic               rsp_ack;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_op
      assign req_op[gi] = req_data[gi*IN_W +: IN_W];
    end
  endgenerate

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req    (req_valid),
    .last   (last_reg),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // Ready is gated by reset so nothing looks accepted while the block is held
  assign req_ready = (rst_n && state_reg == IDLE) ? arb_gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign rsp_ack   = rsp_ready[grant_id_reg];

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE:  if (accept) state_next = DRIVE;
      DRIVE: begin
        if (cnt_reg == 4'd1) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ack) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      last_reg      <= ID_W'(NUM_REQ - 1);
      grant_id_reg  <= '0;
      core_in_reg   <= '0;
      rsp_data_reg  <= '0;
      rsp_valid_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        core_in_reg  <= req_op[arb_id];
        grant_id_reg <= arb_id;
        cnt_reg      <= 4'(CORE_LAT);
      end else if (state_reg == DRIVE) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (capture) begin
        rsp_data_reg  <= core_out;
        rsp_valid_reg <= NUM_REQ'(onehot(MAX_ID_W'(grant_id_reg)));
      end
      // The pointer only advances once the response is taken, so an aborted
      // transaction does not cost the requester its turn
      if (done) begin
        rsp_valid_reg <= '0;
        last_reg      <= grant_id_reg;
      end
    end
  end

  assign core_in   = core_in_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = (state_reg != IDLE);
  assign grant_id  = grant_id_reg;

endmodule

// File: tb/tb_logic_core_arbiter.sv
// Scoreboard bench for logic_core_arbiter: a behavioural core model drives
// core_out, stimulus queues expected responses, a monitor pops and compares them.
module tb_logic_core_arbiter;

  localparam int NR = 4;
  localparam int IW = 14;
  localparam int OW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*IW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [IW-1:0]   core_in;
  logic [OW-1:0]   core_out;
  logic [NR-1:0]   rsp_valid;
  logic [OW-1:0]   rsp_data;
  logic [NR-1:0]   rsp_ready;
  logic            busy;
  logic [1:0]      grant_id;

  typedef struct packed {
    logic [1:0]    id;
    logic [OW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] core_model(input logic [13:0] x);
    logic [7:0] y;
    y[0] = ^x;
    y[1] = &x[3:0];
    y[2] = |x[13:10];
    y[3] = x[5] ^ (x[6] & x[7]);
    y[4] = x[8] | ~x[9];
    y[5] = (x[1:0] == x[3:2]);
    y[6] = x[13] & ~x[0];
    y[7] = (x[12:9] > x[4:1]);
    return y;
  endfunction

  assign core_out = core_model(core_in);

  logic_core_arbiter #(.NUM_REQ(NR), .IN_W(IW), .OUT_W(OW), .CORE_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .core_in   (core_in),
    .core_out  (core_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int k, input logic [13:0] v);
    req_data[k*IW +: IW] = v;
  endtask

  task automatic push(input int k, input logic [13:0] v);
    exp_t e;
    e.id   = 2'(k);
    e.data = core_model(v);
    sb.push_back(e);
  endtask

  // Response monitor: a handshake seen at negedge completes on the next posedge
  always @(negedge clk) begin
    if (rst_n && ((rsp_valid & rsp_ready) != '0)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid %0h data %0h, required no response", rsp_valid, rsp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required finish before 2000000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [13:0] ops [NR];
    int          order [5];
    ops[0] = 14'h0123; ops[1] = 14'h1ABC; ops[2] = 14'h2F0F; ops[3] = 14'h3555;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

    rst_n = 1'b0; req_valid = 4'b0001; req_data = '0; rsp_ready = '0;
    step(3);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_core_in", 32'(core_in), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);

    // Single transaction latency from requester 0
    rst_n = 1'b1;
    set_op(0, 14'h2A5A);
    #1;
    check("t1_req_ready", 32'(req_ready), 32'h1);
    push(0, 14'h2A5A);
    step(1);
    req_valid = '0;
    check("t1_core_in", 32'(core_in), 32'h2A5A);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_rsp_early0", 32'(rsp_valid), 32'h0);
    step(1);
    check("t1_rsp_early1", 32'(rsp_valid), 32'h0);
    step(1);
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_data", 32'(rsp_data), 32'(core_model(14'h2A5A)));
    rsp_ready = 4'b1111;
    step(1);
    check("t1_idle", 32'(busy), 32'h0);

    // Reset so the pointer restarts at requester 0, then full contention
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int k = 0; k < NR; k++) set_op(k, ops[k]);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_order", 32'(req_ready), 32'(4'b0001 << order[i]));
      push(order[i], ops[order[i]]);
      step(1);
      if (i == 4) req_valid = '0;
      check("rr_grant_id", 32'(grant_id), 32'(order[i]));
      step(3);
    end

    // Requester 0 stalls its response; the wrong requesters acknowledge
    rsp_ready = 4'b1110;
    set_op(0, 14'h1357);
    set_op(2, 14'h0BEE);
    req_valid = 4'b0001;
    #1;
    check("st_req_ready", 32'(req_ready), 32'h1);
    push(0, 14'h1357);
    step(1);
    req_valid = 4'b0100;
    step(2);
    for (int i = 0; i < 10; i++) begin
      check("st_rsp_valid", 32'(rsp_valid), 32'h1);
      check("st_rsp_data", 32'(rsp_data), 32'(core_model(14'h1357)));
      check("st_req_ready", 32'(req_ready), 32'h0);
      check("st_busy", 32'(busy), 32'h1);
      step(1);
    end
    rsp_ready = 4'b1111;
    step(1);
    check("st_grant2", 32'(req_ready), 32'h4);
    push(2, 14'h0BEE);
    step(1);
    req_valid = '0;
    step(3);

    // Reset in DRIVE aborts the operand without any response
    set_op(1, 14'h0F0F);
    req_valid = 4'b0010;
    #1;
    check("ab_req_ready", 32'(req_ready), 32'h2);
    step(1);
    req_valid = '0;
    check("ab_drive", 32'(busy), 32'h1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_rsp_valid", 32'(rsp_valid), 32'h0);
    check("ab_core_in", 32'(core_in), 32'h0);
    check("ab_grant_id", 32'(grant_id), 32'h0);
    step(5);
    check("ab_no_rsp", 32'(rsp_valid), 32'h0);

    // Exhaustive operand sweep through requester 1
    for (int v = 0; v < 16384; v++) begin
      set_op(1, 14'(v));
      req_valid = 4'b0010;
      #1;
      check("sw_req_ready", 32'(req_ready), 32'h2);
      push(1, 14'(v));
      step(4);
    end
    req_valid = '0;
    step(3);
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
